// File: rtl/custom_buff_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : custom_buff_seq_counter
// Purpose  : Steps the 5-bit schedule count 0..LAST_CNT per tile for a latched
//            number of tiles, feeding the buffer-use decoder.
// Revision : 1.0 - initial release
// ============================================================================
module custom_buff_seq_counter #(
    parameter int CNT_W    = 5,
    parameter int LAST_CNT = 25,
    parameter int TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tile,
    input  logic              stall,
    input  logic              abort,
    output logic [CNT_W-1:0]  cnt,
    output logic              cnt_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(LAST_CNT);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [TILE_W-1:0] r_tile;
    logic [TILE_W-1:0] r_num;
    logic [TILE_W-1:0] w_last_tile;

    // r_num is nonzero whenever RUN is entered, so this never underflows in use
    assign w_last_tile = r_num - TILE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tile  <= '0;
            r_num   <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tile  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_tile <= '0;
                        r_num  <= num_tile;
                        r_state <= (num_tile != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (r_cnt != c_last_cnt) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else if (r_tile != w_last_tile) begin
                            r_cnt  <= '0;
                            r_tile <= r_tile + TILE_W'(1);
                        end else begin
                            r_cnt   <= '0;
                            r_tile  <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_tile  <= '0;
                end
            endcase
        end
    end

    assign cnt       = r_cnt;
    assign tile_idx  = r_tile;
    assign cnt_valid = (r_state == S_RUN) && !stall;
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_custom_buff_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_buff_seq_counter
// Purpose  : Scoreboard bench for custom_buff_seq_counter with directed runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_custom_buff_seq_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_tile;
    logic       stall;
    logic       abort;
    logic [4:0] cnt;
    logic       cnt_valid;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;

    custom_buff_seq_counter #(.CNT_W(5), .LAST_CNT(25), .TILE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tile(num_tile),
        .stall(stall), .abort(abort), .cnt(cnt), .cnt_valid(cnt_valid),
        .tile_idx(tile_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
        int tile;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected valid cycles of a run; s7/s25 stalled cycles precede the valid cnt=7
    // of tile 0 and the valid cnt=25 of the last tile.
    task automatic push_run(input int c0, input int n, input int s7, input int s25,
                            input int limit, input bit with_done);
        int k = 1;
        int pushed = 0;
        exp_t e;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c <= 25; c++) begin
                if (limit >= 0 && pushed >= limit) return;
                if (t == 0 && c == 7) k += s7;
                if (t == n - 1 && c == 25) k += s25;
                e.cyc = c0 + k; e.cnt = c; e.tile = t;
                exp_q.push_back(e);
                pushed++;
                k++;
            end
        end
        if (with_done) done_q.push_back(c0 + k);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT presents output.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (cnt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("cnt", int'(cnt), e.cnt);
                check("tile_idx", int'(tile_idx), e.tile);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check("unexpected_done", 1, 0);
            else check("done_cycle", cyc, done_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; start = 1'b1; num_tile = 8'd1; stall = 1'b0; abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_cnt", int'(cnt), 0);
            check("rst_valid", int'(cnt_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_tile", int'(tile_idx), 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        // Single tile; next run starts in the first IDLE cycle
        c0 = cyc; num_tile = 8'd1; start = 1'b1;
        push_run(c0, 1, 0, 0, -1, 1'b1);
        @(negedge clk); start = 1'b0;
        check("t1_busy_c1", int'(busy), 1);
        wait_cyc(c0 + 27);
        check("t1_busy_c27", int'(busy), 1);
        wait_cyc(c0 + 28);
        check("t1_idle_c28", int'(busy), 0);

        // Three tiles with an ignored restart mid-run
        c0 = cyc; num_tile = 8'd3; start = 1'b1;
        push_run(c0, 3, 0, 0, -1, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 40);
        start = 1'b1; num_tile = 8'd9;
        @(negedge clk); start = 1'b0; num_tile = 8'd3;
        wait_cyc(c0 + 80);
        check("t2_idle", int'(busy), 0);

        // Stall 4 cycles at cnt=7 and 1 cycle at cnt=25
        c0 = cyc; num_tile = 8'd1; start = 1'b1;
        push_run(c0, 1, 4, 1, -1, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 8);
        check("t3_cnt_pre_stall", int'(cnt), 7);
        stall = 1'b1;
        wait_cyc(c0 + 11);
        check("t3_cnt_hold7", int'(cnt), 7);
        wait_cyc(c0 + 12); stall = 1'b0;
        wait_cyc(c0 + 30);
        check("t3_cnt_25", int'(cnt), 25);
        stall = 1'b1;
        wait_cyc(c0 + 31); stall = 1'b0;
        check("t3_cnt_hold25", int'(cnt), 25);
        wait_cyc(c0 + 33);
        check("t3_idle", int'(busy), 0);

        // Abort at tile 1, cnt 10
        c0 = cyc; num_tile = 8'd2; start = 1'b1;
        push_run(c0, 2, 0, 0, 37, 1'b0);
        @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 37);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_cnt", int'(cnt), 0);
        check("abort_tile", int'(tile_idx), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        c0 = cyc; num_tile = 8'd1; start = 1'b1;
        push_run(c0, 1, 0, 0, -1, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_cyc(c0 + 28);

        // Abort together with start in IDLE stays idle
        start = 1'b1; abort = 1'b1; num_tile = 8'd4;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);

        // Zero tiles
        c0 = cyc; num_tile = 8'd0; start = 1'b1;
        done_q.push_back(c0 + 1);
        @(negedge clk); start = 1'b0;
        check("zero_busy_c1", int'(busy), 1);
        @(negedge clk);
        check("zero_idle_c2", int'(busy), 0);

        for (int i = 0; i < 60 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        check("drain_valid_q", exp_q.size(), 0);
        check("drain_done_q", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/custom_buff_seq_counter.md
# custom_buff_seq_counter

Sequencer that generates the 5-bit schedule count consumed by the buffer-use decoder in the custom datapath. On `start` it steps `cnt` through 0..LAST_CNT once per tile for a latched number of tiles, honours a downstream `stall`, supports `abort`, and flags completion with a one-cycle `done`. It sits directly upstream of the buffer-use decoder; the decoder's `buff_use` is meaningful only while `cnt_valid` is high.

## Interface
- `CNT_W`, default 5, width of `cnt`.
- `LAST_CNT`, default 25, final count value of one tile sequence.
- `TILE_W`, default 8, width of tile count and tile index.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_tile`  in  TILE_W  tiles to run; latched when `start` is accepted.
- `stall`  in  1  hold the sequence; no advance while high.
- `abort`  in  1  cancel the run; return to IDLE with no `done`.
- `cnt`  out  CNT_W  current schedule count, to the decoder.
- `cnt_valid`  out  1  `cnt` is live this cycle.
- `tile_idx`  out  TILE_W  index of the current tile, 0-based.
- `busy`  out  1  state is RUN or DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. Registers: state, `cnt`, `tile_idx`, latched `num_tile` (`num_r`).
- Priority on each edge: `rst` > `abort` > normal transitions.
- `rst`: state=IDLE, `cnt`=0, `tile_idx`=0, `num_r`=0. All outputs 0.
- `abort` (any state): next state IDLE, `cnt`=0, `tile_idx`=0; `done` not asserted.
- IDLE: `start`=1 and `num_tile`!=0 -> RUN, `cnt`=0, `tile_idx`=0, `num_r`=`num_tile`. `start`=1 and `num_tile`==0 -> DONE (no counts issued). Otherwise stay.
- RUN, `stall`=1: all registers hold.
- RUN, `stall`=0:
  - `cnt`<LAST_CNT: `cnt`+1.
  - `cnt`==LAST_CNT and `tile_idx`<`num_r`-1: `cnt`=0, `tile_idx`+1.
  - `cnt`==LAST_CNT and `tile_idx`==`num_r`-1: -> DONE, `cnt`=0, `tile_idx`=0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` outside IDLE is ignored; `num_tile` changes after acceptance have no effect.
- `cnt_valid` = (state==RUN) & ~`stall`. `busy` = RUN | DONE. `done` = (state==DONE). All decoded from registered state; `cnt` and `tile_idx` are registers.
- `cnt` never exceeds LAST_CNT; `tile_idx` never reaches `num_r`. Arithmetic is unsigned; no wrap beyond the explicit reset-to-0 at LAST_CNT.

## Timing
- `start` sampled at edge E0 -> RUN from E0, `cnt`=0 and `cnt_valid`=1 in the cycle after E0.
- One unstalled tile: 26 valid cycles (`cnt` 0..25), `done` in cycle 27 after E0, IDLE from cycle 28; a new `start` is accepted in that cycle.
- N unstalled tiles: 26·N valid cycles back-to-back, no bubble between tiles; `done` in cycle 26·N+1.
- Each stalled cycle extends the run by exactly one cycle; `cnt` visible but `cnt_valid`=0.
- `num_tile`=0: `done` in the cycle after E0, `cnt_valid` never asserts.
- `abort` sampled at edge: outputs idle from the next cycle; `abort` in the same cycle as `start` in IDLE wins (stays IDLE).
- `stall` in the final count cycle delays both the transition to DONE and the `done` pulse.

## Test plan
- Reset: `rst`=1 for 2 cycles with `start`=1 -> `cnt`=0, `cnt_valid`=0, `busy`=0, `done`=0, `tile_idx`=0 throughout; state IDLE after release.
- Single tile: `num_tile`=1, pulse `start` -> `cnt` 0..25 on 26 consecutive valid cycles, `done`=1 exactly on cycle 27, `busy` high cycles 1..27.
- Multi-tile with ignored restart: `num_tile`=3, then `start`=1 with `num_tile`=9 mid-run -> 78 valid cycles, `tile_idx` 0/1/2 each for 26 cycles, `cnt` wraps 25->0 without bubble, `done` on cycle 79.
- Stall: `num_tile`=1, `stall`=1 for 4 cycles at `cnt`=7 and 1 cycle at `cnt`=25 -> `cnt` holds at 7 and 25, `cnt_valid`=0 during stalls, `done` on cycle 32.
- Abort: `num_tile`=2, `abort` at `tile_idx`=1, `cnt`=10 -> next cycle `cnt`=0, `tile_idx`=0, `busy`=0, no `done`; fresh `start` with `num_tile`=1 then completes normally.
- Zero tiles: `num_tile`=0, `start` -> `done`=1 on cycle 1, `cnt_valid` never high, IDLE on cycle 2.
